// File: rtl/pmc_counter_bank.sv
// pmc_counter_bank: saturating performance counters plus a restoring-divider CPI unit.
// Define PMC_STALL_PER_SRC_EN to add one saturating counter per stall source.
module pmc_counter_bank #(
  parameter int CNT_W         = 64,
  parameter int FRAC_W        = 8,
  parameter int NUM_STALL_SRC = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     clear,
  input  logic                     instr_valid,
  input  logic                     mem_write,
  input  logic                     mem_to_reg,
  input  logic [2:0]               alu_control,
  input  logic                     jmp,
  input  logic [1:0]               branch,
  input  logic [NUM_STALL_SRC-1:0] stall_src,
  input  logic                     snapshot_req,
  output logic [CNT_W-1:0]         cycle_count,
  output logic [CNT_W-1:0]         instr_count,
  output logic [CNT_W-1:0]         stall_count,
  output logic [CNT_W-1:0]         arith_count,
  output logic [CNT_W-1:0]         mem_count,
  output logic [CNT_W-1:0]         ctrl_count,
  output logic [5:0]               ovf,
  output logic [CNT_W-1:0]         cpi_q,
  output logic                     cpi_valid,
  output logic                     busy,
  output logic                     div_zero
`ifdef PMC_STALL_PER_SRC_EN
  ,
  output logic [NUM_STALL_SRC*CNT_W-1:0] stall_src_count,
  output logic [NUM_STALL_SRC-1:0]       stall_src_ovf
`endif
);

  localparam int DIV_W  = CNT_W + FRAC_W;
  localparam int ITER_W = $clog2(DIV_W + 1);

  logic             retire;
  logic             is_mem;
  logic             is_ctrl;
  logic [5:0]       inc;
  logic [CNT_W-1:0] cnt_q [6];

  assign retire  = enable & instr_valid;
  assign is_mem  = mem_write | mem_to_reg;
  assign is_ctrl = jmp | (branch != 2'b00);

  // Bit order: cycle, instr, stall, arith, mem, ctrl
  assign inc = {retire & is_ctrl,
                retire & is_mem,
                retire & ~is_mem & ~is_ctrl & (alu_control != 3'b100),
                enable & (|stall_src),
                retire,
                enable};

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;
      logic             ovf_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (clear) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (inc[gi]) begin
          if (&cnt_reg) ovf_reg <= 1'b1;
          else          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign cnt_q[gi] = cnt_reg;
      assign ovf[gi]   = ovf_reg;
    end
  endgenerate

  assign cycle_count = cnt_q[0];
  assign instr_count = cnt_q[1];
  assign stall_count = cnt_q[2];
  assign arith_count = cnt_q[3];
  assign mem_count   = cnt_q[4];
  assign ctrl_count  = cnt_q[5];

`ifdef PMC_STALL_PER_SRC_EN
  generate
    for (gi = 0; gi < NUM_STALL_SRC; gi++) begin : g_src
      logic [CNT_W-1:0] src_cnt_reg;
      logic             src_ovf_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          src_cnt_reg <= '0;
          src_ovf_reg <= 1'b0;
        end else if (clear) begin
          src_cnt_reg <= '0;
          src_ovf_reg <= 1'b0;
        end else if (enable & stall_src[gi]) begin
          if (&src_cnt_reg) src_ovf_reg <= 1'b1;
          else              src_cnt_reg <= src_cnt_reg + 1'b1;
        end
      end
      assign stall_src_count[gi*CNT_W +: CNT_W] = src_cnt_reg;
      assign stall_src_ovf[gi]                  = src_ovf_reg;
    end
  endgenerate
`endif

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] dq_reg;     // dividend bits shift out MSB-first as quotient bits shift in
  logic [CNT_W-1:0] rem_reg;
  logic [CNT_W-1:0] dvsr_reg;
  logic [ITER_W-1:0] iter_reg;
  logic             zero_reg;
  logic [CNT_W:0]   rem_shift;
  logic [CNT_W:0]   rem_sub;

  assign rem_shift = {rem_reg, dq_reg[DIV_W-1]};
  assign rem_sub   = rem_shift - {1'b0, dvsr_reg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      dq_reg    <= '0;
      rem_reg   <= '0;
      dvsr_reg  <= '0;
      iter_reg  <= '0;
      zero_reg  <= 1'b0;
      cpi_q     <= '0;
      cpi_valid <= 1'b0;
      busy      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      cpi_valid <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (snapshot_req) begin
            dq_reg    <= {cnt_q[0], {FRAC_W{1'b0}}};
            dvsr_reg  <= cnt_q[1];
            rem_reg   <= '0;
            iter_reg  <= '0;
            zero_reg  <= (cnt_q[1] == '0);
            busy      <= 1'b1;
            state_reg <= (cnt_q[1] == '0) ? DONE : DIV;
          end
        end
        DIV: begin
          // A clear borrow bit means the shifted remainder covered the divisor
          dq_reg   <= {dq_reg[DIV_W-2:0], ~rem_sub[CNT_W]};
          rem_reg  <= rem_sub[CNT_W] ? rem_shift[CNT_W-1:0] : rem_sub[CNT_W-1:0];
          iter_reg <= iter_reg + ITER_W'(1);
          if (iter_reg == ITER_W'(DIV_W - 1)) state_reg <= DONE;
        end
        DONE: begin
          if (zero_reg || (|dq_reg[DIV_W-1:CNT_W])) cpi_q <= '1;
          else                                      cpi_q <= dq_reg[CNT_W-1:0];
          div_zero  <= zero_reg;
          cpi_valid <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pmc_counter_bank.sv
// Randomised self-checking bench for pmc_counter_bank (16-bit instance plus an
// 8-bit instance for saturation), checked against an arithmetic event-count model.
module tb_pmc_counter_bank;

  localparam int     CNT_W  = 16;
  localparam int     FRAC_W = 8;
  localparam int     NS     = 4;
  localparam longint MAX16  = 65535;
  localparam longint MAX8   = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0, clear = 1'b0, instr_valid = 1'b0;
  logic mem_write = 1'b0, mem_to_reg = 1'b0, jmp = 1'b0, snapshot_req = 1'b0;
  logic [2:0]    alu_control = 3'd0;
  logic [1:0]    branch = 2'd0;
  logic [NS-1:0] stall_src = '0;

  logic [CNT_W-1:0] cycle_count, instr_count, stall_count, arith_count, mem_count, ctrl_count;
  logic [5:0]       ovf;
  logic [CNT_W-1:0] cpi_q;
  logic             cpi_valid, busy, div_zero;

  logic [7:0] c8_cycle, c8_instr, c8_stall, c8_arith, c8_mem, c8_ctrl, c8_cpi_q;
  logic [5:0] c8_ovf;
  logic       c8_cpi_valid, c8_busy, c8_div_zero;

`ifdef PMC_STALL_PER_SRC_EN
  logic [NS*CNT_W-1:0] stall_src_count;
  logic [NS-1:0]       stall_src_ovf;
  logic [NS*8-1:0]     c8_src_count;
  logic [NS-1:0]       c8_src_ovf;
`endif

  pmc_counter_bank #(.CNT_W(CNT_W), .FRAC_W(FRAC_W), .NUM_STALL_SRC(NS)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .instr_valid(instr_valid),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_control(alu_control), .jmp(jmp),
    .branch(branch), .stall_src(stall_src), .snapshot_req(snapshot_req),
    .cycle_count(cycle_count), .instr_count(instr_count), .stall_count(stall_count),
    .arith_count(arith_count), .mem_count(mem_count), .ctrl_count(ctrl_count), .ovf(ovf),
    .cpi_q(cpi_q), .cpi_valid(cpi_valid), .busy(busy), .div_zero(div_zero)
`ifdef PMC_STALL_PER_SRC_EN
    , .stall_src_count(stall_src_count), .stall_src_ovf(stall_src_ovf)
`endif
  );

  pmc_counter_bank #(.CNT_W(8), .FRAC_W(8), .NUM_STALL_SRC(NS)) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .instr_valid(instr_valid),
    .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_control(alu_control), .jmp(jmp),
    .branch(branch), .stall_src(stall_src), .snapshot_req(snapshot_req),
    .cycle_count(c8_cycle), .instr_count(c8_instr), .stall_count(c8_stall),
    .arith_count(c8_arith), .mem_count(c8_mem), .ctrl_count(c8_ctrl), .ovf(c8_ovf),
    .cpi_q(c8_cpi_q), .cpi_valid(c8_cpi_valid), .busy(c8_busy), .div_zero(c8_div_zero)
`ifdef PMC_STALL_PER_SRC_EN
    , .stall_src_count(c8_src_count), .stall_src_ovf(c8_src_ovf)
`endif
  );

  initial forever #5 clk = ~clk;

  int vectors;
  int errors;

  logic [CNT_W-1:0] dut_cnt [6];
  assign dut_cnt[0] = cycle_count;
  assign dut_cnt[1] = instr_count;
  assign dut_cnt[2] = stall_count;
  assign dut_cnt[3] = arith_count;
  assign dut_cnt[4] = mem_count;
  assign dut_cnt[5] = ctrl_count;

  // Reference model: event totals kept as plain integers, clamped at the counter maximum
  longint m_cnt [6];
  bit     m_ovf [6];
  longint m8_cycle;
  bit     m8_ovf0;
  longint m_src [NS];

  function automatic void reset_model();
    for (int i = 0; i < 6; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
    for (int i = 0; i < NS; i++) m_src[i] = 0;
    m8_cycle = 0; m8_ovf0 = 0;
  endfunction

  function automatic void model_tick();
    bit ret, is_mem, is_ctrl;
    bit ev [6];
    ret     = enable && instr_valid;
    is_mem  = mem_write || mem_to_reg;
    is_ctrl = jmp || (branch != 2'b00);
    ev[0] = enable;
    ev[1] = ret;
    ev[2] = enable && (stall_src != '0);
    ev[3] = ret && !is_mem && !is_ctrl && (alu_control != 3'd4);
    ev[4] = ret && is_mem;
    ev[5] = ret && is_ctrl;
    for (int i = 0; i < 6; i++) begin
      if (clear) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      else if (ev[i]) begin
        if (m_cnt[i] == MAX16) m_ovf[i] = 1;
        else m_cnt[i] = m_cnt[i] + 1;
      end
    end
    for (int i = 0; i < NS; i++) begin
      if (clear) m_src[i] = 0;
      else if (enable && stall_src[i] && m_src[i] < MAX16) m_src[i] = m_src[i] + 1;
    end
    if (clear) begin m8_cycle = 0; m8_ovf0 = 0; end
    else if (enable) begin
      if (m8_cycle == MAX8) m8_ovf0 = 1;
      else m8_cycle = m8_cycle + 1;
    end
  endfunction

  function automatic longint cpi_expect(longint cyc, longint ins, longint maxv);
    longint q;
    if (ins == 0) return maxv;
    q = (cyc * (longint'(1) << FRAC_W)) / ins;
    return (q > maxv) ? maxv : q;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic idle_inputs();
    enable = 0; clear = 0; instr_valid = 0; mem_write = 0; mem_to_reg = 0;
    alu_control = 3'd0; jmp = 0; branch = 2'd0; stall_src = '0; snapshot_req = 0;
  endtask

  // Pulses snapshot_req, optionally re-requests at wait cycle 'reprobe', returns latency (0 = timeout)
  task automatic run_snapshot(input int reprobe, output int lat, output logic busy_after);
    snapshot_req = 1;
    tick();
    busy_after = busy;
    snapshot_req = 0;
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      snapshot_req = (k == reprobe);
      tick();
      if (cpi_valid) begin lat = k; break; end
    end
    snapshot_req = 0;
  endtask

  task automatic test_reset_startup();
    reset = 0;
    reset_model();
    #1;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (dut_cnt[i] !== '0) begin errors++; $display("FAIL reset_cnt[%0d] got=%h exp=0", i, dut_cnt[i]); end
    end
    vectors++;
    if ({ovf, cpi_q, cpi_valid, busy, div_zero} !== '0) begin
      errors++; $display("FAIL reset_status got ovf=%b cpi_q=%h v=%b b=%b z=%b exp all 0", ovf, cpi_q, cpi_valid, busy, div_zero);
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
  endtask

  task automatic test_cpi_basic();
    int lat; logic b; longint exp_q; int extra;
    idle_inputs(); clear = 1; tick(); clear = 0;
    enable = 1; instr_valid = 1; alu_control = 3'b010;
    repeat (10) tick();
    idle_inputs();
    vectors++;
    if ({cycle_count, instr_count, arith_count, mem_count, ctrl_count} !== {16'd10, 16'd10, 16'd10, 16'd0, 16'd0}) begin
      errors++; $display("FAIL basic_counts got cyc=%0d ins=%0d ari=%0d mem=%0d ctl=%0d exp 10/10/10/0/0",
                         cycle_count, instr_count, arith_count, mem_count, ctrl_count);
    end
    exp_q = cpi_expect(m_cnt[0], m_cnt[1], MAX16);
    run_snapshot(5, lat, b);
    vectors++;
    if (b !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", b); end
    vectors++;
    if (lat != 25) begin errors++; $display("FAIL basic_latency got=%0d exp=25", lat); end
    vectors++;
    if (cpi_q !== 16'h0100 || cpi_q !== exp_q[15:0]) begin errors++; $display("FAIL basic_cpi got=%h exp=0100", cpi_q); end
    vectors++;
    if (div_zero !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags got z=%b b=%b exp 0/0", div_zero, busy); end
    extra = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (cpi_valid) extra++; end
    vectors++;
    if (extra != 0) begin errors++; $display("FAIL basic_ignored_req got %0d extra pulses exp 0", extra); end
  endtask

  task automatic test_mix();
    int lat; logic b; int kind;
    idle_inputs(); clear = 1; tick(); clear = 0;
    enable = 1;
    for (int c = 0; c < 20; c++) begin
      instr_valid = 0; mem_write = 0; mem_to_reg = 0; jmp = 0; branch = 2'd0; alu_control = 3'd0;
      if (c % 2 == 0) begin
        instr_valid = 1;
        kind = (c / 2) % 5;
        case (kind)
          0: begin mem_write = 1; alu_control = 3'b010; end
          1: begin mem_to_reg = 1; alu_control = 3'b010; end
          2: begin branch = 2'b01; alu_control = 3'b110; end
          3: jmp = 1;
          default: alu_control = 3'b010;
        endcase
      end
      tick();
    end
    idle_inputs();
    vectors++;
    if ({cycle_count, instr_count, arith_count, mem_count, ctrl_count} !== {16'd20, 16'd10, 16'd2, 16'd4, 16'd4}) begin
      errors++; $display("FAIL mix_counts got cyc=%0d ins=%0d ari=%0d mem=%0d ctl=%0d exp 20/10/2/4/4",
                         cycle_count, instr_count, arith_count, mem_count, ctrl_count);
    end
    run_snapshot(0, lat, b);
    vectors++;
    if (lat != 25 || cpi_q !== 16'h0200) begin errors++; $display("FAIL mix_cpi got lat=%0d cpi=%h exp 25/0200", lat, cpi_q); end
  endtask

  task automatic test_div_zero();
    int lat; logic b; int extra;
    idle_inputs(); clear = 1; tick(); clear = 0;
    run_snapshot(1, lat, b);
    vectors++;
    if (lat != 1 || b !== 1'b1) begin errors++; $display("FAIL dz_latency got lat=%0d busy=%b exp 1/1", lat, b); end
    vectors++;
    if (cpi_q !== 16'hFFFF || div_zero !== 1'b1) begin errors++; $display("FAIL dz_result got cpi=%h z=%b exp FFFF/1", cpi_q, div_zero); end
    extra = 0;
    for (int k = 0; k < 30; k++) begin tick(); if (cpi_valid) extra++; end
    vectors++;
    if (extra != 0) begin errors++; $display("FAIL dz_ignored_req got %0d extra pulses exp 0", extra); end
  endtask

  task automatic test_saturation();
    int lat; logic b; longint exp_q;
    idle_inputs(); clear = 1; tick(); clear = 0;
    enable = 1;
    repeat (300) tick();
    vectors++;
    if (c8_cycle !== 8'hFF || c8_ovf[0] !== 1'b1 || c8_ovf[1] !== 1'b0 || c8_cycle !== m8_cycle[7:0]) begin
      errors++; $display("FAIL sat8_cycle got cnt=%h ovf=%b exp FF ovf[0]=1", c8_cycle, c8_ovf);
    end
    vectors++;
    if (cycle_count !== 16'(m_cnt[0]) || ovf[0] !== 1'b0) begin errors++; $display("FAIL sat16_cycle got %0d exp %0d", cycle_count, m_cnt[0]); end
    instr_valid = 1; alu_control = 3'b010; tick();
    idle_inputs();
    exp_q = cpi_expect(m_cnt[0], m_cnt[1], MAX16);
    run_snapshot(0, lat, b);
    vectors++;
    if (lat != 25 || cpi_q !== exp_q[15:0] || cpi_q !== 16'hFFFF || div_zero !== 1'b0) begin
      errors++; $display("FAIL sat_quotient got lat=%0d cpi=%h z=%b exp 25/FFFF/0", lat, cpi_q, div_zero);
    end
    vectors++;
    if (c8_cpi_q !== 8'hFF || c8_div_zero !== 1'b0) begin errors++; $display("FAIL sat8_quotient got cpi=%h z=%b exp FF/0", c8_cpi_q, c8_div_zero); end
    enable = 1; clear = 1; tick(); idle_inputs();
    vectors++;
    if (c8_cycle !== 8'h00 || c8_ovf[0] !== 1'b0 || cycle_count !== 16'h0) begin
      errors++; $display("FAIL clear_priority got c8=%h ovf0=%b c16=%h exp 0/0/0", c8_cycle, c8_ovf[0], cycle_count);
    end
  endtask

  task automatic test_stall();
    idle_inputs(); clear = 1; tick(); clear = 0;
    enable = 1; stall_src = 4'b0110;
    repeat (5) tick();
    idle_inputs();
    vectors++;
    if (stall_count !== 16'd5 || cycle_count !== 16'd5 || instr_count !== 16'd0) begin
      errors++; $display("FAIL stall_count got stall=%0d cyc=%0d ins=%0d exp 5/5/0", stall_count, cycle_count, instr_count);
    end
`ifdef PMC_STALL_PER_SRC_EN
    for (int i = 0; i < NS; i++) begin
      vectors++;
      if (stall_src_count[i*CNT_W +: CNT_W] !== ((i == 1 || i == 2) ? 16'd5 : 16'd0) || stall_src_ovf[i] !== 1'b0) begin
        errors++; $display("FAIL stall_src[%0d] got %0d ovf=%b", i, stall_src_count[i*CNT_W +: CNT_W], stall_src_ovf[i]);
      end
    end
`endif
  endtask

  task automatic test_random();
    int lat; logic b; longint exp_q; int exp_lat; int len;
    for (int r = 0; r < 8; r++) begin
      len = int'($urandom_range(5, 40));
      for (int c = 0; c < len; c++) begin
        enable      = ($urandom_range(0, 3) != 0);
        clear       = ($urandom_range(0, 40) == 0);
        instr_valid = 1'($urandom_range(0, 1));
        mem_write   = ($urandom_range(0, 4) == 0);
        mem_to_reg  = ($urandom_range(0, 4) == 0);
        alu_control = 3'($urandom_range(0, 7));
        jmp         = ($urandom_range(0, 5) == 0);
        branch      = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        stall_src   = NS'($urandom);
        tick();
        for (int i = 0; i < 6; i++) begin
          vectors++;
          if (dut_cnt[i] !== 16'(m_cnt[i]) || ovf[i] !== m_ovf[i]) begin
            errors++; $display("FAIL rand_cnt[%0d] got %0d ovf=%b exp %0d ovf=%b", i, dut_cnt[i], ovf[i], m_cnt[i], m_ovf[i]);
          end
        end
      end
      clear = 0;
      exp_q   = cpi_expect(m_cnt[0], m_cnt[1], MAX16);
      exp_lat = (m_cnt[1] == 0) ? 1 : 25;
      run_snapshot(0, lat, b);
      vectors++;
      if (lat != exp_lat || cpi_q !== exp_q[15:0] || div_zero !== (exp_lat == 1)) begin
        errors++; $display("FAIL rand_cpi[%0d] got lat=%0d cpi=%h z=%b exp lat=%0d cpi=%h", r, lat, cpi_q, div_zero, exp_lat, exp_q[15:0]);
      end
    end
  endtask

  task automatic test_reset_mid_division();
    int extra;
    idle_inputs(); enable = 1; instr_valid = 1; alu_control = 3'b010;
    repeat (4) tick();
    idle_inputs();
    snapshot_req = 1; tick(); snapshot_req = 0;
    repeat (5) tick();
    reset = 0;
    reset_model();
    #2;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (dut_cnt[i] !== '0) begin errors++; $display("FAIL rst_mid_cnt[%0d] got=%h exp=0", i, dut_cnt[i]); end
    end
    vectors++;
    if ({ovf, cpi_q, cpi_valid, busy, div_zero} !== '0) begin
      errors++; $display("FAIL rst_mid_status got ovf=%b cpi=%h v=%b b=%b z=%b exp all 0", ovf, cpi_q, cpi_valid, busy, div_zero);
    end
    vectors++;
    if ({c8_cycle, c8_instr, c8_stall, c8_arith, c8_mem, c8_ctrl, c8_ovf, c8_cpi_q, c8_cpi_valid, c8_busy, c8_div_zero} !== '0) begin
      errors++; $display("FAIL rst_mid_c8 got nonzero outputs on 8-bit instance");
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1;
    extra = 0;
    for (int k = 0; k < 40; k++) begin tick(); if (cpi_valid || busy) extra++; end
    vectors++;
    if (extra != 0) begin errors++; $display("FAIL rst_mid_discard got %0d busy/valid cycles exp 0", extra); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0;
    errors  = 0;
    reset_model();
    #2;
    test_reset_startup();
    test_cpi_basic();
    test_mix();
    test_div_zero();
    test_saturation();
    test_stall();
    test_random();
    test_reset_mid_division();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
